instruction_decoder: RTL

- Fetch/decode sequencer sitting directly upstream of the datapath.
- Fetches 32-bit instruction words from instruction memory over a req/ack handshake and decodes them into the datapath control bundle: op, form, vec, A–D, Y1, Y2, zero_reg, write, const_a, constant, program_counter_inc.
- Issues exactly one write strobe and one program_counter_inc pulse per retired instruction.

---
 rtl/instruction_decoder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - fetch/decode sequencer feeding the datapath control bundle
//
// Fetches 32-bit words over a req/ack handshake, decodes them and presents the
// datapath control fields. One write strobe and one program_counter_inc pulse
// are issued per retired instruction.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               leave IDLE/HALTED and begin fetching
//   imem_req/addr       fetch request and address
//   imem_ack/rdata      fetch accept, word valid in the same cycle
//   op, form, vec       ALU op, form select, vector mode
//   A, B, C, D          source register indices
//   Y1, Y2              destination register indices
//   zero_reg            zero mask latch (SETZ)
//   write               register write enables, EXEC cycle only
//   const_a, constant   constant-substitution select and extension word
//   program_counter_inc one-cycle retire pulse
//   halted              high in HALTED
module instruction_decoder #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [2:0]            op,
  output logic                  form,
  output logic [1:0]            vec,
  output logic [3:0]            A,
  output logic [3:0]            B,
  output logic [3:0]            C,
  output logic [3:0]            D,
  output logic [3:0]            Y1,
  output logic [3:0]            Y2,
  output logic [3:0]            zero_reg,
  output logic [1:0]            write,
  output logic                  const_a,
  output logic [31:0]           constant,
  output logic                  program_counter_inc,
  output logic                  halted
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_FETCH_EXT = 3'd2;
  localparam logic [2:0] S_EXEC      = 3'd3;
  localparam logic [2:0] S_HALTED    = 3'd4;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOADK = 2'b01;
  localparam logic [1:0] CLS_SETZ  = 2'b10;
  localparam logic [1:0] CLS_HALT  = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_TWO = ADDR_WIDTH'(2);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [2:0]            op_q;
  logic                  form_q;
  logic [1:0]            vec_q;
  logic [3:0]            a_q, b_q, c_q, d_q, y1_q, y2_q;
  logic [3:0]            zero_q;
  logic [1:0]            wr_q;
  logic                  const_a_q;
  logic [31:0]           constant_q;
  logic                  pinc_q;

  logic [1:0] word_cls;
  logic       base_ack;
  logic       ext_ack;

  assign word_cls = imem_rdata[31:30];
  assign base_ack = (state_q == S_FETCH) && imem_ack;
  assign ext_ack  = (state_q == S_FETCH_EXT) && imem_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          case (word_cls)
            CLS_LOADK: state_d = S_FETCH_EXT;
            CLS_HALT:  state_d = S_HALTED;
            default:   state_d = S_EXEC;
          endcase
        end
      end
      S_FETCH_EXT: if (imem_ack) state_d = S_EXEC;
      S_EXEC:      state_d = S_FETCH;
      S_HALTED:    if (start) state_d = S_FETCH;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      op_q       <= '0;
      form_q     <= 1'b0;
      vec_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      zero_q     <= '0;
      wr_q       <= '0;
      const_a_q  <= 1'b0;
      constant_q <= '0;
      pinc_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Retire pulse lands in the EXEC cycle, or the first HALTED cycle.
      pinc_q  <= (state_d == S_EXEC) || (base_ack && (word_cls == CLS_HALT));

      if (base_ack) begin
        case (word_cls)
          CLS_ALU, CLS_LOADK: begin
            op_q      <= imem_rdata[29:27];
            form_q    <= imem_rdata[26];
            vec_q     <= imem_rdata[25:24];
            a_q       <= imem_rdata[23:20];
            b_q       <= imem_rdata[19:16];
            c_q       <= imem_rdata[15:12];
            d_q       <= imem_rdata[11:8];
            y1_q      <= imem_rdata[7:4];
            y2_q      <= imem_rdata[3:0];
            const_a_q <= (word_cls == CLS_LOADK);
            wr_q      <= {imem_rdata[3:0] != 4'd0, imem_rdata[7:4] != 4'd0};
          end
          CLS_SETZ: begin
            zero_q    <= imem_rdata[3:0];
            const_a_q <= 1'b0;
            wr_q      <= 2'b00;
          end
          default: begin
            // HALT never visits EXEC, so step past the HALT word here.
            const_a_q <= 1'b0;
            wr_q      <= 2'b00;
            pc_q      <= pc_q + PC_ONE;
          end
        endcase
      end

      if (ext_ack) constant_q <= imem_rdata;

      // const_a is set only by a LOADK decode, so it doubles as the step-2 flag.
      if (state_q == S_EXEC) pc_q <= pc_q + (const_a_q ? PC_TWO : PC_ONE);
    end
  end

  always_comb begin
    imem_addr = '0;
    if (state_q == S_FETCH)     imem_addr = pc_q;
    if (state_q == S_FETCH_EXT) imem_addr = pc_q + PC_ONE;
  end

  assign imem_req            = (state_q == S_FETCH) || (state_q == S_FETCH_EXT);
  assign write               = (state_q == S_EXEC) ? wr_q : 2'b00;
  assign program_counter_inc = pinc_q;
  assign halted              = (state_q == S_HALTED);
  assign op                  = op_q;
  assign form                = form_q;
  assign vec                 = vec_q;
  assign A                   = a_q;
  assign B                   = b_q;
  assign C                   = c_q;
  assign D                   = d_q;
  assign Y1                  = y1_q;
  assign Y2                  = y2_q;
  assign zero_reg            = zero_q;
  assign const_a             = const_a_q;
  assign constant            = constant_q;

endmodule
